// File: rtl/div_pkg.sv
// +----------------------------------------------------------------------------
// | div_pkg : shared types and sizing for the seq_divider_8 restoring divider
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {
    HALT  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    SHIFT = 3'd3,
    TRIAL = 3'd4,
    FIXUP = 3'd5,
    HOLD  = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_trial_sub.sv
// +----------------------------------------------------------------------------
// | div_trial_sub : trial subtraction A - D, one bit wider than A so the sign
// |                 bit of the difference decides restore vs. keep
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module div_trial_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH+1:0] diff,
  output logic             nonneg
);

  assign diff   = {1'b0, a} - {2'b00, d};
  assign nonneg = ~diff[WIDTH+1];

endmodule

`default_nettype wire

// File: rtl/seq_divider_8.sv
// +----------------------------------------------------------------------------
// | seq_divider_8 : sequential restoring divider, quotient in B, remainder in A
// |                 Define SIGNED_DIV_EN for two's complement operands (FIXUP).
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module seq_divider_8
  import div_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Done,
  output logic             DivZero
);

  localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_d;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_div_zero;
  logic [WIDTH+1:0]   w_diff;
  logic               w_nonneg;
  logic               w_unused_diff_msb;

`ifdef SIGNED_DIV_EN
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_dividend;
  localparam state_t c_AFTER_LAST = FIXUP;
`else
  localparam state_t c_AFTER_LAST = HOLD;
`endif

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .a      (r_a),
    .d      (r_d),
    .diff   (w_diff),
    .nonneg (w_nonneg)
  );

  // The sign bit is consumed inside the trial block as nonneg.
  assign w_unused_diff_msb = w_diff[WIDTH+1];

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= HALT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HALT: begin
        if (Run)               w_next = START;
        else if (ClearA_LoadB) w_next = LOAD;
      end
      LOAD:    w_next = HALT;
      START:   w_next = SHIFT;
      SHIFT:   w_next = TRIAL;
      TRIAL:   w_next = (r_cnt == c_LAST) ? c_AFTER_LAST : SHIFT;
      FIXUP:   w_next = HOLD;
      HOLD:    if (!Run) w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dividend <= '0;
`endif
    end else begin
      case (r_state)
        LOAD: begin
          r_b <= S;
          r_a <= '0;
        end
        START: begin
          r_a        <= '0;
          r_cnt      <= '0;
          r_div_zero <= (S == '0);
`ifdef SIGNED_DIV_EN
          // Iterate on magnitudes; the most negative value still fits unsigned.
          r_d        <= S[WIDTH-1] ? (-S) : S;
          r_b        <= r_b[WIDTH-1] ? (-r_b) : r_b;
          r_sign_q   <= r_b[WIDTH-1] ^ S[WIDTH-1];
          r_sign_r   <= r_b[WIDTH-1];
          r_dividend <= r_b;
`else
          r_d        <= S;
`endif
        end
        SHIFT: {r_a, r_b} <= {r_a[WIDTH-1:0], r_b, 1'b0};
        TRIAL: begin
          if (w_nonneg) r_a <= w_diff[WIDTH:0];
          r_b[0] <= w_nonneg;
          if (r_cnt != c_LAST) r_cnt <= r_cnt + 1'b1;
        end
`ifdef SIGNED_DIV_EN
        FIXUP: begin
          if (r_div_zero) begin
            r_b <= '1;
            r_a <= {r_dividend[WIDTH-1], r_dividend};
          end else begin
            if (r_sign_q) r_b <= -r_b;
            if (r_sign_r) r_a <= -r_a;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign Aval    = r_a[WIDTH-1:0];
  assign Bval    = r_b;
  assign Done    = (r_state == HOLD);
  assign DivZero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_8.sv
// +----------------------------------------------------------------------------
// | tb_seq_divider_8 : self-checking bench for seq_divider_8 (SIGNED_DIV_EN aware)
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider_8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic [7:0] S = 8'h00;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       Done;
  logic       DivZero;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SIGNED_DIV_EN
  localparam int c_LAT = 19;
`else
  localparam int c_LAT = 18;
`endif

  seq_divider_8 dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .Done         (Done),
    .DivZero      (DivZero)
  );

  always #5 Clk = ~Clk;

  // Reference: plain arithmetic division with the divide-by-zero convention.
  function automatic void ref_div(input logic [7:0] n, input logic [7:0] d,
                                  output logic [7:0] q, output logic [7:0] r);
    if (d == 8'h00) begin
      q = 8'hFF;
      r = n;
    end else begin
`ifdef SIGNED_DIV_EN
      int sn;
      int sd;
      sn = int'($signed(n));
      sd = int'($signed(d));
      q  = 8'(sn / sd);
      r  = 8'(sn % sd);
`else
      q = n / d;
      r = n % d;
`endif
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    S = v;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    tick();
  endtask

  // Returns the edge number on which Done is first seen (0 if it never rises).
  task automatic do_run(input logic [7:0] s, output int lat);
    S   = s;
    Run = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (Done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_run();
    Run = 1'b0;
    tick();
  endtask

  task automatic check_result(input string tag, input logic [7:0] n, input logic [7:0] d, input int lat);
    logic [7:0] q;
    logic [7:0] r;
    ref_div(n, d, q, r);
    n_cmp++;
    if (lat !== c_LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d (n=%h d=%h)", tag, lat, c_LAT, n, d);
    end
    n_cmp++;
    if (Bval !== q) begin
      n_err++;
      $display("FAIL %s quotient: got %h expected %h (n=%h d=%h)", tag, Bval, q, n, d);
    end
    n_cmp++;
    if (Aval !== r) begin
      n_err++;
      $display("FAIL %s remainder: got %h expected %h (n=%h d=%h)", tag, Aval, r, n, d);
    end
    n_cmp++;
    if (DivZero !== (d == 8'h00)) begin
      n_err++;
      $display("FAIL %s divzero: got %b expected %b", tag, DivZero, (d == 8'h00));
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    n_cmp++;
    if ({Aval, Bval, Done, DivZero} !== 18'h0) begin
      n_err++;
      $display("FAIL reset: got A=%h B=%h Done=%b DZ=%b expected all zero", Aval, Bval, Done, DivZero);
    end
  endtask

  task automatic test_load();
    do_load(8'hA5);
    n_cmp++;
    if (Bval !== 8'hA5 || Aval !== 8'h00) begin
      n_err++;
      $display("FAIL load: got A=%h B=%h expected A=00 B=a5", Aval, Bval);
    end
  endtask

  task automatic test_directed();
    int lat;
    do_load(8'd100);
    do_run(8'd7, lat);
    check_result("div100_7", 8'd100, 8'd7, lat);
    n_cmp++;
    if (Bval !== 8'd14 || Aval !== 8'd2) begin
      n_err++;
      $display("FAIL div100_7 literal: got B=%0d A=%0d expected B=14 A=2", Bval, Aval);
    end
    release_run();
`ifdef SIGNED_DIV_EN
    do_load(8'h9C);
    do_run(8'd7, lat);
    n_cmp++;
    if (lat !== 19 || Bval !== 8'hF2 || Aval !== 8'hFE) begin
      n_err++;
      $display("FAIL signed_m100_7: got lat=%0d B=%h A=%h expected 19 f2 fe", lat, Bval, Aval);
    end
    release_run();
    do_load(8'h80);
    do_run(8'hFF, lat);
    n_cmp++;
    if (Bval !== 8'h80 || Aval !== 8'h00) begin
      n_err++;
      $display("FAIL signed_m128_m1: got B=%h A=%h expected 80 00", Bval, Aval);
    end
    release_run();
`endif
  endtask

  task automatic test_chain();
    int lat;
    logic [7:0] q1;
    logic [7:0] r1;
    do_load(8'd255);
    do_run(8'd1, lat);
    check_result("chain_first", 8'd255, 8'd1, lat);
    ref_div(8'd255, 8'd1, q1, r1);
    release_run();
    do_run(8'd16, lat);
    check_result("chain_second", q1, 8'd16, lat);
`ifndef SIGNED_DIV_EN
    n_cmp++;
    if (Bval !== 8'd15 || Aval !== 8'd15) begin
      n_err++;
      $display("FAIL chain literal: got B=%0d A=%0d expected 15 15", Bval, Aval);
    end
`endif
    release_run();
  endtask

  task automatic test_div_zero();
    int lat;
    logic [7:0] q1;
    logic [7:0] r1;
    do_load(8'd7);
    do_run(8'd0, lat);
    check_result("divzero", 8'd7, 8'd0, lat);
    release_run();
    n_cmp++;
    if (DivZero !== 1'b1) begin
      n_err++;
      $display("FAIL divzero_sticky: got %b expected 1", DivZero);
    end
    ref_div(8'd7, 8'd0, q1, r1);
    do_run(8'd1, lat);
    check_result("divzero_clear", q1, 8'd1, lat);
    release_run();
  endtask

  task automatic test_hold();
    int lat;
    logic [7:0] qb;
    logic [7:0] ab;
    do_load(8'd200);
    do_run(8'd9, lat);
    check_result("hold_entry", 8'd200, 8'd9, lat);
    ref_div(8'd200, 8'd9, qb, ab);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (Done !== 1'b1 || Bval !== qb || Aval !== ab) begin
        n_err++;
        $display("FAIL hold cycle %0d: got Done=%b B=%h A=%h expected 1 %h %h", i, Done, Bval, Aval, qb, ab);
      end
    end
    release_run();
    n_cmp++;
    if (Done !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: got Done=%b expected 0", Done);
    end
  endtask

  task automatic test_priority();
    int lat;
    do_load(8'd50);
    ClearA_LoadB = 1'b1;
    do_run(8'd3, lat);
    ClearA_LoadB = 1'b0;
    check_result("run_over_load", 8'd50, 8'd3, lat);
    release_run();
  endtask

  task automatic test_mid_reset();
    do_load(8'd200);
    S   = 8'd9;
    Run = 1'b1;
    repeat (8) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Run   = 1'b0;
    n_cmp++;
    if ({Aval, Bval, Done, DivZero} !== 18'h0) begin
      n_err++;
      $display("FAIL mid_reset: got A=%h B=%h Done=%b DZ=%b expected all zero", Aval, Bval, Done, DivZero);
    end
    do_load(8'h5A);
    n_cmp++;
    if (Bval !== 8'h5A || Aval !== 8'h00) begin
      n_err++;
      $display("FAIL load_after_reset: got A=%h B=%h expected 00 5a", Aval, Bval);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] n;
    logic [7:0] d;
    for (int k = 0; k < 24; k++) begin
      n = 8'($urandom_range(0, 255));
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      do_load(n);
      do_run(d, lat);
      check_result("random", n, d, lat);
      release_run();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_directed();
    test_chain();
    test_div_zero();
    test_hold();
    test_priority();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
